// File: rtl/jtcps1_pkg.sv
// Shared CPS-1 constants: palette geometry and the palette-DMA state encoding.
package jtcps1_pkg;

  localparam int PAL_PAGE_WORDS = 512;
  localparam int PAL_PAGES      = 6;
  localparam int PAGE_W         = 3;
  localparam int WORD_W         = $clog2(PAL_PAGE_WORDS);

  typedef logic [2:0] pal_state_t;

  localparam pal_state_t ST_IDLE = 3'd0;
  localparam pal_state_t ST_SEEK = 3'd1;
  localparam pal_state_t ST_ADDR = 3'd2;
  localparam pal_state_t ST_WAIT = 3'd3;
  localparam pal_state_t ST_READ = 3'd4;
  localparam pal_state_t ST_NEXT = 3'd5;

endpackage

// File: rtl/jtcps1_pal_pagesel.sv
// Finds the lowest enabled palette page at or above a starting page.
module jtcps1_pal_pagesel
  import jtcps1_pkg::*;
#(
  parameter int PAGES = PAL_PAGES
) (
  input  logic [PAGES-1:0]  mask_i,
  input  logic [PAGE_W-1:0] start_i,
  output logic [PAGE_W-1:0] page_o,
  output logic              none_o
);

  // Scanning downwards lets the lowest qualifying page win the last assignment.
  always_comb begin
    page_o = '0;
    none_o = 1'b1;
    for (int p = PAGES - 1; p >= 0; p--) begin
      if (mask_i[p] && (p >= int'(start_i))) begin
        page_o = PAGE_W'(p);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/jtcps1_pal_dma.sv
// CPS-1 palette copy sequencer: waits for vertical blank, then copies the enabled
// 512-word palette pages from VRAM into the colour mixer palette RAM.
module jtcps1_pal_dma
  import jtcps1_pkg::*;
#(
  parameter int PAGES = PAL_PAGES,
  parameter int AW    = 18
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             pal_copy,
  input  logic [15:0]      pal_base,
  input  logic [PAGES-1:0] pal_page_en,
  input  logic             VB,
  output logic [AW-1:0]    vram_addr,
  output logic             vram_cs,
  input  logic [15:0]      vram_data,
  input  logic             vram_ok,
  output logic             pal_we,
  output logic [11:0]      pal_waddr,
  output logic [15:0]      pal_wdata,
  output logic             busy
);

  pal_state_t        state_q, state_d;
  logic              pending_q, pending_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [AW-1:0]     base_q, base_d;
  logic [PAGES-1:0]  mask_q, mask_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              cs_q, cs_d;
  logic              we_q, we_d;
  logic [11:0]       waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;

  logic [PAGE_W-1:0] sel_page;
  logic              sel_none;
  logic              unused_base;

  assign unused_base = ^pal_base[15:11];

  jtcps1_pal_pagesel #(.PAGES(PAGES)) u_pagesel (
    .mask_i  (mask_q),
    .start_i (page_q),
    .page_o  (sel_page),
    .none_o  (sel_none)
  );

  // A request arriving in the start cycle stays pending for a second copy.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | pal_copy;
    page_d    = page_q;
    word_d    = word_q;
    base_d    = base_q;
    mask_d    = mask_q;
    addr_d    = addr_q;
    cs_d      = cs_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pending_q && VB) begin
          base_d    = AW'({pal_base[10:0], 7'd0});
          mask_d    = pal_page_en;
          pending_d = pal_copy;
          page_d    = '0;
          state_d   = ST_SEEK;
        end
      end
      ST_SEEK: begin
        if (sel_none) begin
          cs_d    = 1'b0;
          state_d = ST_IDLE;
        end else begin
          page_d  = sel_page;
          word_d  = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        addr_d  = base_q + AW'({page_q, word_q});
        cs_d    = 1'b1;
        state_d = ST_WAIT;
      end
      // vram_ok here may still refer to the previous address, so it is ignored.
      ST_WAIT: state_d = ST_READ;
      ST_READ: begin
        if (vram_ok) begin
          we_d    = 1'b1;
          waddr_d = {page_q, word_q};
          wdata_d = vram_data;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        word_d = word_q + 1'b1;
        if (word_q == WORD_W'(PAL_PAGE_WORDS - 1)) begin
          page_d  = page_q + 1'b1;
          state_d = ST_SEEK;
        end else begin
          state_d = ST_ADDR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      page_q    <= '0;
      word_q    <= '0;
      base_q    <= '0;
      mask_q    <= '0;
      addr_q    <= '0;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      page_q    <= page_d;
      word_q    <= word_d;
      base_q    <= base_d;
      mask_q    <= mask_d;
      addr_q    <= addr_d;
      cs_q      <= cs_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign vram_addr = addr_q;
  assign vram_cs   = cs_q;
  assign pal_we    = we_q;
  assign pal_waddr = waddr_q;
  assign pal_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
